// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : step_sequencer
//  Description : Manual step / peek front end for the instruction controller.
//                Synchronises the debounced step (CLKb) and peek (PeeKb)
//                keys, turns each press into a one-cycle strobe, advances a
//                one-hot timestep counter T0..T3 on every step and latches
//                the instruction word on the T0 step. A peek press produces
//                a one-cycle request carrying the captured register select.
//
//  Ports       : CLK_50MHz  in   1      system clock (rising edge)
//                Reset_n    in   1      synchronous active-low reset
//                CLKb       in   1      step key, active-low
//                PeeKb      in   1      peek key, active-low
//                databus    in   WIDTH  instruction / data word
//                data2bit   in   2      peek register select
//                Done       in   1      instruction finished this timestep
//                AutoRun    in   1      auto-step request
//                Step       out  1      one-cycle step strobe
//                Timestep   out  4      one-hot {T3,T2,T1,T0}
//                Instr      out  WIDTH  instruction latched at the T0 step
//                InstrValid out  1      high from T0 latch until return to T0
//                PeekReq    out  1      one-cycle peek strobe
//                PeekSel    out  2      data2bit captured on the peek press
//
//  Config      : STEP_AUTORUN_EN - when defined, AutoRun issues one Step
//                every AUTO_DIV cycles. Undefined: AutoRun is ignored.
//
//  Revision    : 1.0  initial release
// ============================================================================
module step_sequencer #(
   parameter int WIDTH       = 10,
   parameter int SYNC_STAGES = 2,         // minimum 2
   parameter int AUTO_DIV    = 25000000
) (
   input  logic             CLK_50MHz,
   input  logic             Reset_n,
   input  logic             CLKb,
   input  logic             PeeKb,
   input  logic [WIDTH-1:0] databus,
   input  logic [1:0]       data2bit,
   input  logic             Done,
   input  logic             AutoRun,
   output logic             Step,
   output logic [3:0]       Timestep,
   output logic [WIDTH-1:0] Instr,
   output logic             InstrValid,
   output logic             PeekReq,
   output logic [1:0]       PeekSel
);

   typedef enum logic [3:0] {
      ST_T0 = 4'b0001,
      ST_T1 = 4'b0010,
      ST_T2 = 4'b0100,
      ST_T3 = 4'b1000
   } state_t;

   // ------------------------------------------------------------------------
   // Key synchronisers and press detection
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] peek_sync_q;
   logic                   clk_prev_q;
   logic                   peek_prev_q;
   // Tracks how many stages hold real key samples since reset. The chain
   // resets to "released", so a key held through reset would otherwise
   // look like a fresh 1->0 press once the first real samples arrive.
   logic [SYNC_STAGES:0]   fill_q;
   logic                   step_q;
   logic                   step_d;
   logic                   peek_req_q;
   logic [1:0]             peek_sel_q;
   logic                   w_clk_edge;
   logic                   w_peek_edge;
   logic                   w_auto_hit;

   assign w_clk_edge  = fill_q[SYNC_STAGES] & clk_prev_q
                        & ~clk_sync_q[SYNC_STAGES-1];
   assign w_peek_edge = fill_q[SYNC_STAGES] & peek_prev_q
                        & ~peek_sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK_50MHz) begin
      if (!Reset_n) begin
         clk_sync_q  <= '1;
         peek_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         peek_prev_q <= 1'b1;
         fill_q      <= '0;
         step_q      <= 1'b0;
         peek_req_q  <= 1'b0;
         peek_sel_q  <= 2'b00;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], CLKb};
         peek_sync_q <= {peek_sync_q[SYNC_STAGES-2:0], PeeKb};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
         peek_prev_q <= peek_sync_q[SYNC_STAGES-1];
         fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
         step_q      <= step_d;
         peek_req_q  <= w_peek_edge;
         if (w_peek_edge) begin
            peek_sel_q <= data2bit;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Optional auto-step divider
   // ------------------------------------------------------------------------
`ifdef STEP_AUTORUN_EN
   localparam int C_CNT_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(AUTO_DIV - 1);

   logic [C_CNT_W-1:0] auto_cnt_q;

   assign w_auto_hit = AutoRun & (auto_cnt_q == C_CNT_LAST);

   always_ff @(posedge CLK_50MHz) begin
      if (!Reset_n || !AutoRun) begin
         auto_cnt_q <= '0;
      end else if (auto_cnt_q == C_CNT_LAST) begin
         auto_cnt_q <= '0;
      end else begin
         auto_cnt_q <= auto_cnt_q + 1'b1;
      end
   end
`else
   logic w_unused_autorun;
   assign w_auto_hit       = 1'b0;
   assign w_unused_autorun = AutoRun & (AUTO_DIV > 0);
`endif

   // A key step and an auto step landing together collapse into one strobe.
   assign step_d = w_clk_edge | w_auto_hit;

   // ------------------------------------------------------------------------
   // Timestep FSM
   // ------------------------------------------------------------------------
   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   instr_q;
   logic [WIDTH-1:0]   instr_d;
   logic               instr_valid_q;
   logic               instr_valid_d;

   always_ff @(posedge CLK_50MHz) begin
      if (!Reset_n) begin
         state_q       <= ST_T0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      case (state_q)
         ST_T0: begin
            if (step_q) begin
               state_d       = ST_T1;
               instr_d       = databus;
               instr_valid_d = 1'b1;
            end
         end
         ST_T1: begin
            if (step_q) begin
               if (Done) begin
                  state_d       = ST_T0;
                  instr_valid_d = 1'b0;
               end else begin
                  state_d = ST_T2;
               end
            end
         end
         ST_T2: begin
            if (step_q) begin
               if (Done) begin
                  state_d       = ST_T0;
                  instr_valid_d = 1'b0;
               end else begin
                  state_d = ST_T3;
               end
            end
         end
         ST_T3: begin
            if (step_q) begin
               state_d       = ST_T0;
               instr_valid_d = 1'b0;
            end
         end
         default: begin
            // Any non-one-hot encoding recovers to T0 on the next clock.
            state_d       = ST_T0;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   assign Step       = step_q;
   assign Timestep   = state_q;
   assign Instr      = instr_q;
   assign InstrValid = instr_valid_q;
   assign PeekReq    = peek_req_q;
   assign PeekSel    = peek_sel_q;

endmodule
`default_nettype wire
